// File: rtl/posit_to_fir_pkg.sv
// Shared types and width helpers for the posit unpacker and the PPU datapath.
// fir_t below is sized for the default 8-bit, ES=0 posit configuration.
package posit_to_fir_pkg;

  function automatic int te_w(input int n, input int es);
    return $clog2(n) + es + 2;
  endfunction

  function automatic int frac_w(input int n);
    return n;
  endfunction

  // Two's complement, widest supported posit is 32 bits.
  function automatic logic [31:0] c2(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  localparam int FIR_N      = 8;
  localparam int FIR_ES     = 0;
  localparam int FIR_TE_W   = te_w(FIR_N, FIR_ES);
  localparam int FIR_FRAC_W = frac_w(FIR_N);

  typedef struct packed {
    logic                        sign;
    logic signed [FIR_TE_W-1:0]  te;
    logic [FIR_FRAC_W-1:0]       frac;
  } fir_t;

endpackage

// File: rtl/posit_to_fir_dec.sv
// Combinational posit field decoder: sign, specials, regime k, exponent,
// regime length (run plus terminator) and the magnitude word.
module posit_to_fir_dec
  import posit_to_fir_pkg::*;
#(
  parameter int N     = 8,
  parameter int ES    = 0,
  parameter int S     = $clog2(N),
  parameter int EXP_W = (ES > 0) ? ES : 1
) (
  input  logic [N-1:0]     i_bits,
  output logic             o_sign,
  output logic             o_is_zero,
  output logic             o_is_nar,
  output logic signed [S:0] o_k,
  output logic [EXP_W-1:0] o_exp,
  output logic [S-1:0]     o_reg_len,
  output logic [N-1:0]     o_mant
);

  logic [N-1:0] w_abs;
  logic         w_r0;
  logic         w_term;
  int           w_run;

  always_comb begin
    w_abs  = i_bits[N-1] ? N'(c2(32'(i_bits))) : i_bits;
    w_r0   = w_abs[N-2];
    w_run  = 0;
    w_term = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!w_term) begin
        if (w_abs[i] == w_r0) w_run = w_run + 1;
        else                  w_term = 1'b1;
      end
    end
  end

  assign o_sign    = i_bits[N-1];
  assign o_is_zero = (i_bits == '0);
  assign o_is_nar  = (i_bits == {1'b1, {(N-1){1'b0}}});
  assign o_k       = w_r0 ? (S+1)'(w_run - 1) : (S+1)'(-w_run);
  // A run reaching bit 0 has no terminator, so its length is already N-1.
  assign o_reg_len = w_term ? S'(w_run + 1) : S'(w_run);
  assign o_mant    = w_abs;

  if (ES > 0) begin : g_exp
    logic [N-1:0] w_after_reg;
    assign w_after_reg = w_abs << (int'(o_reg_len) + 1);
    assign o_exp       = EXP_W'(w_after_reg >> (N - ES));
  end else begin : g_noexp
    assign o_exp = '0;
  end

endmodule

// File: rtl/posit_to_fir.sv
// Two-stage posit-to-FIR unpacker: s1 registers decoder fields, s2 registers
// the normalised FIR. Valid/ready on both sides, full throughput.
module posit_to_fir
  import posit_to_fir_pkg::*;
#(
  parameter int N      = 8,
  parameter int ES     = 0,
  parameter int S      = $clog2(N),
  parameter int TE_W   = te_w(N, ES),
  parameter int FRAC_W = frac_w(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_bits,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [TE_W-1:0]   out_te,
  output logic [FRAC_W-1:0] out_frac,
  output logic              out_is_zero,
  output logic              out_is_nar
);

  localparam int EXP_W = (ES > 0) ? ES : 1;

  typedef struct packed {
    logic                    sign;
    logic signed [TE_W-1:0]  te;
    logic [FRAC_W-1:0]       frac;
    logic                    is_zero;
    logic                    is_nar;
  } fir_flags_t;

  logic              w_dec_sign, w_dec_zero, w_dec_nar;
  logic signed [S:0] w_dec_k;
  logic [EXP_W-1:0]  w_dec_exp;
  logic [S-1:0]      w_dec_reg_len;
  logic [N-1:0]      w_dec_mant;

  posit_to_fir_dec #(.N(N), .ES(ES), .S(S), .EXP_W(EXP_W)) u_dec (
    .i_bits    (in_bits),
    .o_sign    (w_dec_sign),
    .o_is_zero (w_dec_zero),
    .o_is_nar  (w_dec_nar),
    .o_k       (w_dec_k),
    .o_exp     (w_dec_exp),
    .o_reg_len (w_dec_reg_len),
    .o_mant    (w_dec_mant)
  );

  logic              r_vld_p1, r_sign_p1, r_zero_p1, r_nar_p1;
  logic signed [S:0] r_k_p1;
  logic [EXP_W-1:0]  r_exp_p1;
  logic [S-1:0]      r_reg_len_p1;
  logic [N-1:0]      r_mant_p1;
  logic              r_vld_p2;
  fir_flags_t        r_fir_p2;

  logic w_adv2, w_load1;

  assign w_adv2   = r_vld_p1 && (!r_vld_p2 || out_ready);
  assign in_ready = !r_vld_p1 || w_adv2;
  assign w_load1  = in_valid && in_ready;

  // ---- stage 1 -> stage 2 boundary: normalise fraction, form total exponent
  int                     w_shamt;
  logic [N-1:0]           w_shifted, w_frac_n;
  logic [FRAC_W-1:0]      w_frac;
  logic signed [TE_W-1:0] w_te;
  fir_flags_t             w_fir;

  if (FRAC_W >= N) begin : g_frac_pad
    assign w_frac = FRAC_W'(w_frac_n) << (FRAC_W - N);
  end else begin : g_frac_cut
    assign w_frac = w_frac_n[N-1 -: FRAC_W];
  end

  always_comb begin
    w_shamt   = int'(r_reg_len_p1) + ES + 1;
    w_shifted = (w_shamt >= N) ? '0 : (r_mant_p1 << w_shamt);
    w_frac_n  = {1'b1, {(N-1){1'b0}}} | (w_shifted >> 1);
    w_te      = (TE_W'(r_k_p1) <<< ES) + $signed(TE_W'(r_exp_p1));
    w_fir         = '0;
    w_fir.sign    = r_sign_p1;
    w_fir.te      = w_te;
    w_fir.frac    = w_frac;
    if (r_zero_p1) begin
      w_fir         = '0;
      w_fir.is_zero = 1'b1;
    end else if (r_nar_p1) begin
      w_fir        = '0;
      w_fir.sign   = 1'b1;
      w_fir.is_nar = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1     <= 1'b0;
      r_sign_p1    <= 1'b0;
      r_zero_p1    <= 1'b0;
      r_nar_p1     <= 1'b0;
      r_k_p1       <= '0;
      r_exp_p1     <= '0;
      r_reg_len_p1 <= '0;
      r_mant_p1    <= '0;
      r_vld_p2     <= 1'b0;
      r_fir_p2     <= '0;
    end else begin
      r_vld_p1 <= w_load1 || (r_vld_p1 && !w_adv2);
      if (w_load1) begin
        r_sign_p1    <= w_dec_sign;
        r_zero_p1    <= w_dec_zero;
        r_nar_p1     <= w_dec_nar;
        r_k_p1       <= w_dec_k;
        r_exp_p1     <= w_dec_exp;
        r_reg_len_p1 <= w_dec_reg_len;
        r_mant_p1    <= w_dec_mant;
      end
      r_vld_p2 <= w_adv2 || (r_vld_p2 && !out_ready);
      if (w_adv2) r_fir_p2 <= w_fir;
    end
  end

  // ---- stage 2 outputs
  assign out_valid   = r_vld_p2;
  assign out_sign    = r_fir_p2.sign;
  assign out_te      = r_fir_p2.te;
  assign out_frac    = r_fir_p2.frac;
  assign out_is_zero = r_fir_p2.is_zero;
  assign out_is_nar  = r_fir_p2.is_nar;

endmodule

// File: tb/tb_posit_to_fir.sv
// Bench for posit_to_fir: an 8-bit ES=0 and a 16-bit ES=1 instance checked
// against a value-level posit decoding model.
module tb_posit_to_fir;

  logic clk = 1'b0;
  logic rst;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic        out_sign8, oz8, on8;
  logic [7:0]  in_bits8, out_frac8;
  logic [4:0]  out_te8;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic        out_sign16, oz16, on16;
  logic [15:0] in_bits16, out_frac16;
  logic [6:0]  out_te16;

  int n_checks, n_fail;

  always #5 clk = ~clk;

  posit_to_fir #(.N(8), .ES(0)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_bits(in_bits8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_sign(out_sign8), .out_te(out_te8),
    .out_frac(out_frac8), .out_is_zero(oz8), .out_is_nar(on8)
  );

  posit_to_fir #(.N(16), .ES(1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .in_bits(in_bits16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_sign(out_sign16), .out_te(out_te16),
    .out_frac(out_frac16), .out_is_zero(oz16), .out_is_nar(on16)
  );

  // Value-level decode: walk the regime, take ES exponent bits (zero-filled when
  // truncated), the remaining bits are the fraction after the hidden one.
  function automatic void model(input int n, input int es, input int bits, output bit s,
                                output int te, output int frac, output bit z, output bit nr);
    int p, a, r0, m, pos, avail, e, fb, k;
    p = bits & ((1 << n) - 1);
    s = 0; te = 0; frac = 0; z = 0; nr = 0;
    if (p == 0) begin z = 1; return; end
    if (p == (1 << (n - 1))) begin s = 1; nr = 1; return; end
    s = (p >= (1 << (n - 1)));
    a = s ? (1 << n) - p : p;
    r0 = (a >> (n - 2)) & 1;
    m = 0; pos = n - 2;
    while (pos >= 0 && ((a >> pos) & 1) == r0) begin m++; pos--; end
    k = r0 ? m - 1 : -m;
    avail = (pos > 0) ? pos : 0;
    if (avail >= es) begin
      e = (a >> (avail - es)) & ((1 << es) - 1); fb = avail - es;
    end else begin
      e = (a & ((1 << avail) - 1)) << (es - avail); fb = 0;
    end
    te = k * (1 << es) + e;
    frac = (1 << (n - 1)) | ((a & ((1 << fb) - 1)) << (n - 1 - fb));
  endfunction

  function automatic logic [15:0] exp8(input logic [7:0] b);
    bit s, z, nr; int te, fr;
    model(8, 0, int'(b), s, te, fr, z, nr);
    return {s, 5'(te), 8'(fr), z, nr};
  endfunction

  function automatic logic [25:0] exp16(input logic [15:0] b);
    bit s, z, nr; int te, fr;
    model(16, 1, int'(b), s, te, fr, z, nr);
    return {s, 7'(te), 16'(fr), z, nr};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL reset_valid8 got %b want 0", out_valid8); end
    n_checks++; if ({out_sign8, out_te8, out_frac8, oz8, on8} !== 16'h0) begin n_fail++; $display("FAIL reset_data8 got %h want 0", {out_sign8, out_te8, out_frac8, oz8, on8}); end
    n_checks++; if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL reset_ready8 got %b want 1", in_ready8); end
    n_checks++; if (out_valid16 !== 1'b0) begin n_fail++; $display("FAIL reset_valid16 got %b want 0", out_valid16); end
    n_checks++; if ({out_sign16, out_te16, out_frac16, oz16, on16} !== 26'h0) begin n_fail++; $display("FAIL reset_data16 got %h want 0", {out_sign16, out_te16, out_frac16, oz16, on16}); end
    n_checks++; if (in_ready16 !== 1'b1) begin n_fail++; $display("FAIL reset_ready16 got %b want 1", in_ready16); end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    in_valid8 = 1'b1; in_bits8 = 8'h40; out_ready8 = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", in_ready8); end
    @(posedge clk); #1 in_valid8 = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL single_early got %b want 0", out_valid8); end
    @(negedge clk);
    n_checks++; if (out_valid8 !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid8); end
    n_checks++;
    if ({out_sign8, out_te8, out_frac8, oz8, on8} !== {1'b0, 5'd0, 8'h80, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL single_data got %h want %h", {out_sign8, out_te8, out_frac8, oz8, on8}, {1'b0, 5'd0, 8'h80, 1'b0, 1'b0});
    end
    @(negedge clk);
    n_checks++; if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL single_dup got %b want 0", out_valid8); end
  endtask

  task automatic test_stream();
    logic [7:0]  w [6];
    logic [15:0] e [6];
    w = '{8'h60, 8'h50, 8'hC0, 8'h01, 8'h00, 8'h80};
    e = '{{1'b0, 5'd1, 8'h80, 2'b00}, {1'b0, 5'd0, 8'hC0, 2'b00}, {1'b1, 5'd0, 8'h80, 2'b00},
          {1'b0, 5'h1A, 8'h80, 2'b00}, {1'b0, 5'd0, 8'h00, 2'b10}, {1'b1, 5'd0, 8'h00, 2'b01}};
    out_ready8 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      in_valid8 = (c < 6);
      if (c < 6) in_bits8 = w[c];
      @(negedge clk);
      if (c < 6) begin
        n_checks++; if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL stream_ready c=%0d got %b want 1", c, in_ready8); end
      end
      if (c >= 2) begin
        n_checks++;
        if (out_valid8 !== 1'b1 || {out_sign8, out_te8, out_frac8, oz8, on8} !== e[c-2]) begin
          n_fail++; $display("FAIL stream_out word=%h got v=%b %h want v=1 %h", w[c-2], out_valid8, {out_sign8, out_te8, out_frac8, oz8, on8}, e[c-2]);
        end
      end
    end
  endtask

  task automatic test_n16();
    logic [15:0] w [2];
    logic [25:0] e [2];
    w = '{16'h5000, 16'h0001};
    e = '{{1'b0, 7'd1, 16'h8000, 2'b00}, {1'b0, 7'h64, 16'h8000, 2'b00}};
    out_ready16 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      in_valid16 = (c < 2);
      if (c < 2) in_bits16 = w[c];
      @(negedge clk);
      if (c >= 2) begin
        n_checks++;
        if (out_valid16 !== 1'b1 || {out_sign16, out_te16, out_frac16, oz16, on16} !== e[c-2]) begin
          n_fail++; $display("FAIL n16_out word=%h got v=%b %h want v=1 %h", w[c-2], out_valid16, {out_sign16, out_te16, out_frac16, oz16, on16}, e[c-2]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  w [3];
    logic [15:0] held;
    int idx, got;
    bit have_held;
    w = '{8'h48, 8'h3A, 8'hB5};
    idx = 0; got = 0; have_held = 0; held = '0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      in_valid8 = (idx < 3);
      in_bits8 = w[(idx < 3) ? idx : 0];
      @(negedge clk);
      if (in_valid8 && in_ready8) idx++;
      if (out_valid8) begin
        if (!have_held) begin
          held = {out_sign8, out_te8, out_frac8, oz8, on8}; have_held = 1;
        end else begin
          n_checks++;
          if ({out_sign8, out_te8, out_frac8, oz8, on8} !== held) begin
            n_fail++; $display("FAIL bp_stable got %h want %h", {out_sign8, out_te8, out_frac8, oz8, on8}, held);
          end
        end
      end
    end
    n_checks++; if (idx !== 2) begin n_fail++; $display("FAIL bp_accepted got %0d want 2", idx); end
    n_checks++; if (in_ready8 !== 1'b0) begin n_fail++; $display("FAIL bp_ready got %b want 0", in_ready8); end
    n_checks++;
    if (out_valid8 !== 1'b1 || {out_sign8, out_te8, out_frac8, oz8, on8} !== exp8(w[0])) begin
      n_fail++; $display("FAIL bp_head got v=%b %h want v=1 %h", out_valid8, {out_sign8, out_te8, out_frac8, oz8, on8}, exp8(w[0]));
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      out_ready8 = 1'b1;
      in_valid8 = (idx < 3);
      in_bits8 = w[(idx < 3) ? idx : 0];
      @(negedge clk);
      if (out_valid8 && out_ready8) begin
        n_checks++;
        if (got >= 3 || {out_sign8, out_te8, out_frac8, oz8, on8} !== exp8(w[(got < 3) ? got : 0])) begin
          n_fail++; $display("FAIL bp_drain n=%0d got %h want %h", got, {out_sign8, out_te8, out_frac8, oz8, on8}, exp8(w[(got < 3) ? got : 0]));
        end
        got++;
      end
      if (in_valid8 && in_ready8) idx++;
    end
    in_valid8 = 1'b0;
    n_checks++; if (got !== 3) begin n_fail++; $display("FAIL bp_count got %0d want 3", got); end
  endtask

  task automatic test_random8();
    logic [7:0]  q [$];
    logic [7:0]  b;
    logic [15:0] prev, act, want;
    bit prev_stall;
    int sent, cyc;
    sent = 0; cyc = 0; prev_stall = 0; prev = '0;
    while ((sent < 300 || q.size() > 0) && cyc < 3000) begin
      @(posedge clk); #1;
      in_valid8 = (sent < 300) && ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       in_bits8 = 8'h00;
        1:       in_bits8 = 8'h80;
        2:       in_bits8 = ($urandom_range(0, 1) != 0) ? 8'h7F : 8'h81;
        default: in_bits8 = 8'($urandom);
      endcase
      out_ready8 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      act = {out_sign8, out_te8, out_frac8, oz8, on8};
      if (prev_stall) begin
        n_checks++;
        if (out_valid8 !== 1'b1 || act !== prev) begin
          n_fail++; $display("FAIL rnd8_hold got v=%b %h want v=1 %h", out_valid8, act, prev);
        end
      end
      if (out_valid8 && out_ready8) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd8_spurious got %h want none", act);
        end else begin
          b = q.pop_front();
          want = exp8(b);
          if (act !== want) begin
            n_fail++; $display("FAIL rnd8_out word=%h got %h want %h", b, act, want);
          end
        end
      end
      if (in_valid8 && in_ready8) begin q.push_back(in_bits8); sent++; end
      prev_stall = out_valid8 && !out_ready8;
      prev = act;
      cyc++;
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    n_checks++; if (sent != 300 || q.size() != 0) begin n_fail++; $display("FAIL rnd8_timeout sent=%0d pending=%0d want 300/0", sent, q.size()); end
  endtask

  task automatic test_random16();
    logic [15:0] q [$];
    logic [15:0] b;
    logic [25:0] act, want;
    int sent, cyc;
    sent = 0; cyc = 0;
    while ((sent < 200 || q.size() > 0) && cyc < 2000) begin
      @(posedge clk); #1;
      in_valid16 = (sent < 200) && ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       in_bits16 = 16'h0000;
        1:       in_bits16 = 16'h8000;
        2:       in_bits16 = 16'($urandom_range(1, 7));
        default: in_bits16 = 16'($urandom);
      endcase
      out_ready16 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      act = {out_sign16, out_te16, out_frac16, oz16, on16};
      if (out_valid16 && out_ready16) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd16_spurious got %h want none", act);
        end else begin
          b = q.pop_front();
          want = exp16(b);
          if (act !== want) begin
            n_fail++; $display("FAIL rnd16_out word=%h got %h want %h", b, act, want);
          end
        end
      end
      if (in_valid16 && in_ready16) begin q.push_back(in_bits16); sent++; end
      cyc++;
    end
    in_valid16 = 1'b0; out_ready16 = 1'b1;
    n_checks++; if (sent != 200 || q.size() != 0) begin n_fail++; $display("FAIL rnd16_timeout sent=%0d pending=%0d want 200/0", sent, q.size()); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      out_ready8 = 1'b0; in_valid8 = 1'b1; in_bits8 = (c == 0) ? 8'h55 : 8'hA3;
    end
    @(posedge clk); #1;
    rst = 1'b1; in_valid8 = 1'b1; in_bits8 = 8'h33;
    @(negedge clk);
    n_checks++; if ({out_valid8, in_ready8} !== 2'b10) begin n_fail++; $display("FAIL rstmid_full got %b want 10", {out_valid8, in_ready8}); end
    @(posedge clk); #1;
    rst = 1'b0; in_valid8 = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", out_valid8); end
    n_checks++; if ({out_sign8, out_te8, out_frac8, oz8, on8} !== 16'h0) begin n_fail++; $display("FAIL rstmid_data got %h want 0", {out_sign8, out_te8, out_frac8, oz8, on8}); end
    n_checks++; if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b want 1", in_ready8); end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1 out_ready8 = 1'b1;
      @(negedge clk);
      if (out_valid8) seen = 1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL rstmid_leak got emission want none"); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1;
    in_valid8 = 1'b0; in_bits8 = '0; out_ready8 = 1'b1;
    in_valid16 = 1'b0; in_bits16 = '0; out_ready16 = 1'b1;
    test_reset();
    test_single();
    test_stream();
    test_n16();
    test_backpressure();
    test_random8();
    test_random16();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
